// File: rtl/rat_alu_mc.sv
// Multi-cycle RAT ALU: single-cycle logic/arith/shift ops plus an iterative shift-add MUL,
// with registered RESULT/RESULT_HI/C/Z and a START/BUSY/DONE handshake.
module rat_alu_mc #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             C,
    output logic             Z
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
    logic               c_q, c_d, z_q, z_d, done_q, done_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_sum;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]     a_x, b_x, arith;
    logic [WIDTH-1:0]   op_res;
    logic               op_c, op_z, wr_res;

    // Single-cycle op unit; arithmetic at WIDTH+1 bits so bit WIDTH is carry/borrow.
    always_comb begin
        a_x    = {1'b0, A};
        b_x    = {1'b0, B};
        arith  = '0;
        op_res = '0;
        op_c   = 1'b0;
        wr_res = 1'b1;
        case (SEL)
            4'd0: begin
                arith  = a_x + b_x;
                op_res = arith[WIDTH-1:0];
                op_c   = arith[WIDTH];
            end
            4'd1: begin
                arith  = a_x + b_x + {{WIDTH{1'b0}}, CIN};
                op_res = arith[WIDTH-1:0];
                op_c   = arith[WIDTH];
            end
            4'd2, 4'd4: begin
                arith  = a_x - b_x;
                op_res = arith[WIDTH-1:0];
                op_c   = arith[WIDTH];
                wr_res = (SEL != 4'd4);
            end
            4'd3: begin
                arith  = a_x - b_x - {{WIDTH{1'b0}}, CIN};
                op_res = arith[WIDTH-1:0];
                op_c   = arith[WIDTH];
            end
            4'd5: op_res = A & B;
            4'd6: op_res = A | B;
            4'd7: op_res = A ^ B;
            4'd8: begin
                op_res = A & B;
                wr_res = 1'b0;
            end
            4'd9: begin
                op_res = {A[WIDTH-2:0], CIN};
                op_c   = A[WIDTH-1];
            end
            4'd10: begin
                op_res = {CIN, A[WIDTH-1:1]};
                op_c   = A[0];
            end
            4'd11: begin
                op_res = {A[WIDTH-2:0], A[WIDTH-1]};
                op_c   = A[WIDTH-1];
            end
            4'd12: begin
                op_res = {A[0], A[WIDTH-1:1]};
                op_c   = A[0];
            end
            4'd13: begin
                op_res = {A[WIDTH-1], A[WIDTH-1:1]};
                op_c   = A[0];
            end
            4'd14: begin
                op_res = B;
                op_c   = CIN;
            end
            default: begin
                op_res = '0;
                op_c   = 1'b0;
            end
        endcase
        op_z = (op_res == '0);
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        hi_d     = hi_q;
        c_d      = c_q;
        z_d      = z_q;
        done_d   = 1'b0;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            StIdle: begin
                if (START) begin
                    if ((SEL == 4'hF) && MUL_EN) begin
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        // CMP and TEST leave both result halves untouched
                        if (wr_res) begin
                            res_d = op_res;
                            hi_d  = '0;
                        end
                        c_d    = op_c;
                        z_d    = op_z;
                        done_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    res_d   = acc_sum[WIDTH-1:0];
                    hi_d    = acc_sum[2*WIDTH-1:WIDTH];
                    c_d     = |acc_sum[2*WIDTH-1:WIDTH];
                    z_d     = (acc_sum == '0);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            res_q    <= '0;
            hi_q     <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            c_q      <= c_d;
            z_q      <= z_d;
            done_q   <= done_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign BUSY      = (state_q == StMul);
    assign DONE      = done_q;
    assign RESULT    = res_q;
    assign RESULT_HI = hi_q;
    assign C         = c_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_rat_alu_mc.sv
// Scoreboard bench for rat_alu_mc: integer reference model feeds an expect queue,
// a negedge monitor pops it on every DONE. A second WIDTH=16, MUL_EN=0 instance is probed directly.
module tb_rat_alu_mc;

    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST, START, CIN, BUSY, DONE, C, Z;
    logic [3:0] SEL;
    logic [7:0] A, B, RESULT, RESULT_HI;

    logic        start16, cin16, busy16, done16, c16, z16;
    logic [3:0]  sel16;
    logic [15:0] a16, b16, res16, hi16;

    rat_alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SEL(SEL), .A(A), .B(B), .CIN(CIN),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RESULT_HI(RESULT_HI), .C(C), .Z(Z)
    );

    rat_alu_mc #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
        .CLK(CLK), .RST(RST), .START(start16), .SEL(sel16), .A(a16), .B(b16), .CIN(cin16),
        .BUSY(busy16), .DONE(done16), .RESULT(res16), .RESULT_HI(hi16), .C(c16), .Z(z16)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        int         at;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Architectural state of the reference model
    logic [7:0] m_res = 0, m_hi = 0;
    logic       m_c = 0, m_z = 0;
    int         busy_end = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_op(input int sel, input int a, input int b, input int cin);
        int   r, p;
        bit   c, keep;
        exp_t e;
        keep = 0;
        r = 0;
        c = 0;
        p = 0;
        case (sel)
            0:  begin r = a + b;           c = (r > 255); end
            1:  begin r = a + b + cin;     c = (r > 255); end
            2:  begin r = a - b;           c = (r < 0);   end
            3:  begin r = a - b - cin;     c = (r < 0);   end
            4:  begin r = a - b;           c = (r < 0);   keep = 1; end
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  begin r = a & b; keep = 1; end
            9:  begin r = a * 2 + cin;               c = (a >= 128); end
            10: begin r = cin * 128 + a / 2;         c = (a % 2 == 1); end
            11: begin r = a * 2 + a / 128;           c = (a >= 128); end
            12: begin r = (a % 2) * 128 + a / 2;     c = (a % 2 == 1); end
            13: begin r = (a & 128) + a / 2;         c = (a % 2 == 1); end
            14: begin r = b;                         c = (cin != 0); end
            default: p = a * b;
        endcase
        if (sel == 15) begin
            m_res = 8'(p & 255);
            m_hi  = 8'(p >> 8);
            m_c   = (m_hi != 0);
            m_z   = (p == 0);
            e.at  = cyc + 1 + W;
            busy_end = cyc + W;
        end else begin
            r = r & 255;
            if (!keep) begin
                m_res = 8'(r);
                m_hi  = 8'h00;
            end
            m_c  = c;
            m_z  = (r == 0);
            e.at = cyc + 1;
        end
        e.res = m_res;
        e.hi  = m_hi;
        e.c   = m_c;
        e.z   = m_z;
        q.push_back(e);
    endtask

    task automatic issue(input int sel, input int a, input int b, input int cin);
        @(posedge CLK);
        #1;
        START = 1'b1;
        SEL   = 4'(sel);
        A     = 8'(a);
        B     = 8'(b);
        CIN   = 1'(cin);
        if (cyc > busy_end) model_op(sel, a, b, cin);
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++) idle();
        chk(name, 32'(q.size()), 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (DONE !== 1'b0) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got DONE=%b at cycle %0d, expected no pending op",
                         DONE, cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("result", 32'(RESULT), 32'(e.res));
                chk("result_hi", 32'(RESULT_HI), 32'(e.hi));
                chk("c_flag", 32'(C), 32'(e.c));
                chk("z_flag", 32'(Z), 32'(e.z));
            end
        end else if (q.size() != 0 && cyc > q[0].at) begin
            e = q.pop_front();
            chk("missing_done", 32'(cyc), 32'(e.at));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        RST = 1'b1; START = 1'b0; SEL = 0; A = 0; B = 0; CIN = 0;
        start16 = 1'b0; sel16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_result", 32'(RESULT), 0);
        chk("rst_result_hi", 32'(RESULT_HI), 0);
        chk("rst_c", 32'(C), 0);
        chk("rst_z", 32'(Z), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        RST = 1'b0;

        // Directed single-cycle ops
        issue(0, 'hFF, 'h01, 0);
        issue(1, 'h01, 'h01, 1);
        issue(2, 'h05, 'h07, 0);
        issue(4, 'h07, 'h07, 0);
        issue(8, 'hF0, 'h0F, 1);
        for (int s = 9; s <= 13; s++) issue(s, 'h81, 'h00, 0);
        issue(14, 'h00, 'h3C, 1);
        drain("drain_directed");

        // MUL FF*FF with an ignored START mid-operation
        busy_cnt = 0;
        issue(15, 'hFF, 'hFF, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 3) issue(0, 'h11, 'h22, 0);
            else idle();
            busy_cnt += (BUSY === 1'b1) ? 1 : 0;
        end
        chk("mul_busy_cycles", 32'(busy_cnt), 8);
        chk("mul_lo_ff", 32'(RESULT), 'h01);
        chk("mul_hi_ff", 32'(RESULT_HI), 'hFE);
        chk("mul_c_ff", 32'(C), 1);
        chk("mul_z_ff", 32'(Z), 0);
        drain("drain_mul");

        // Randomised traffic; STARTs during BUSY are dropped by the model too
        repeat (400) begin
            if ($urandom_range(0, 3) != 0)
                issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
            else
                idle();
        end
        idle();
        drain("drain_random");

        // Reset three cycles into a MUL aborts it without a DONE
        issue(14, 0, 'h5A, 1);
        idle();
        issue(15, 'h9A, 'h37, 0);
        idle(); idle(); idle();
        RST = 1'b1;
        #1;
        chk("abort_result", 32'(RESULT), 0);
        chk("abort_result_hi", 32'(RESULT_HI), 0);
        chk("abort_c", 32'(C), 0);
        chk("abort_z", 32'(Z), 0);
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_done", 32'(DONE), 0);
        q.delete();
        m_res = 0; m_hi = 0; m_c = 0; m_z = 0;
        busy_end = -1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (12) idle();
        issue(0, 'h03, 'h04, 0);
        idle();
        drain("drain_after_abort");

        // WIDTH=16, MUL_EN=0 instance
        @(posedge CLK); #1;
        start16 = 1'b1; sel16 = 4'd14; a16 = 16'h0000; b16 = 16'hBEEF; cin16 = 1'b1;
        @(posedge CLK); #1;
        start16 = 1'b0;
        chk("w16_mov_done", 32'(done16), 1);
        chk("w16_mov_result", 32'(res16), 'hBEEF);
        chk("w16_mov_c", 32'(c16), 1);
        @(posedge CLK); #1;
        start16 = 1'b1; sel16 = 4'd15; a16 = 16'h1234; b16 = 16'h0101; cin16 = 1'b1;
        @(posedge CLK); #1;
        start16 = 1'b0;
        chk("w16_nop_done", 32'(done16), 1);
        chk("w16_nop_busy", 32'(busy16), 0);
        chk("w16_nop_result", 32'(res16), 0);
        chk("w16_nop_hi", 32'(hi16), 0);
        chk("w16_nop_c", 32'(c16), 0);
        chk("w16_nop_z", 32'(z16), 1);
        @(posedge CLK); #1;
        start16 = 1'b1; sel16 = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
        @(posedge CLK); #1;
        start16 = 1'b0;
        chk("w16_add_done", 32'(done16), 1);
        chk("w16_add_result", 32'(res16), 0);
        chk("w16_add_c", 32'(c16), 1);
        chk("w16_add_z", 32'(z16), 1);
        @(posedge CLK); #1;
        chk("w16_done_pulse", 32'(done16), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
